// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus between the fetch sequencer and instruction memory.
//   imem_req    : fetch request, valid together with imem_addr
//   imem_addr   : word-aligned fetch address
//   imem_rvalid : instruction data valid (never asserted in the request cycle)
//   imem_rdata  : returned instruction word
// master = fetch sequencer side, slave = memory side.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch and PC-sequencing stage in front of the single-cycle MIPS
// controller/datapath. Holds the PC, fetches one instruction at a time over the
// imem bus, presents it to decode with a one-cycle exec_en strobe and, at the
// end of that execute cycle, advances the PC using the controller's pcsel.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   run            : 1 = allow new fetches, 0 = idle in FETCH with no request
//   pcsel          : 00 pc+4, 01 branch, 10 jump, 11 jr (sampled in EXEC only)
//   imm/jaddr      : branch offset (words) / jump target field
//   jr_target      : register value for JR
//   imem           : fetch bus (master side)
//   instr, exec_en : latched instruction and one-cycle execute strobe
//   pc, pc_plus4   : current PC and its link value
//   fetch_err      : sticky, a fetch timed out
//   align_err      : sticky, a JR target was not word aligned
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic [1:0]                pcsel,
  input  logic [15:0]               imm,
  input  logic [25:0]               jaddr,
  input  logic [31:0]               jr_target,
  fetch_sequencer_if.master         imem,
  output logic [31:0]               instr,
  output logic                      exec_en,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  output logic                      fetch_err,
  output logic                      align_err
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [31:0]   pc_reg;
  logic [31:0]   instr_reg;
  logic [CW-1:0] cnt_reg;
  logic          fetch_err_reg;
  logic          align_err_reg;
  logic [31:0]   pc_next;

  assign pc_plus4 = pc_reg + 32'd4;

  // Next-PC selection; only consumed at the end of EXEC.
  always_comb begin
    pc_next = pc_plus4;
    case (pcsel)
      2'b00:   pc_next = pc_plus4;
      2'b01:   pc_next = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
      2'b10:   pc_next = {pc_plus4[31:28], jaddr, 2'b00};
      default: pc_next = {jr_target[31:2], 2'b00};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_FETCH;
      pc_reg        <= RESET_PC;
      instr_reg     <= 32'h0;
      cnt_reg       <= '0;
      fetch_err_reg <= 1'b0;
      align_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          // Request is presented combinationally this cycle when run=1.
          if (run) begin
            state_reg <= S_WAIT;
            cnt_reg   <= '0;
          end
        end
        S_WAIT: begin
          // A response in the last allowed cycle still wins over the timeout.
          if (imem.imem_rvalid) begin
            instr_reg <= imem.imem_rdata;
            state_reg <= S_EXEC;
          end else if (cnt_reg == CNT_LAST) begin
            fetch_err_reg <= 1'b1;
            state_reg     <= S_FETCH;   // retry the same pc
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_EXEC: begin
          pc_reg <= pc_next;
          if (pcsel == 2'b11 && jr_target[1:0] != 2'b00)
            align_err_reg <= 1'b1;
          state_reg <= S_FETCH;
        end
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign imem.imem_req  = (state_reg == S_FETCH) && run;
  assign imem.imem_addr = pc_reg;
  assign exec_en        = (state_reg == S_EXEC);
  assign pc             = pc_reg;
  assign instr          = instr_reg;
  assign fetch_err      = fetch_err_reg;
  assign align_err      = align_err_reg;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and PC-sequencing stage, directly upstream of the single-cycle MIPS controller/datapath.
- Holds the PC and issues a request/valid handshake to instruction memory.
- Latches the returned instruction and presents it to decode with a one-cycle execute strobe, which drives the controller's enable.
- On the execute cycle, consumes the controller's pcsel and branch/jump operands to compute the next PC.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.
TIMEOUT, 16, max cycles in WAIT before a fetch is abandoned and retried (≥1).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  1 = allow new fetches; 0 = hold in FETCH, no request
pcsel  input  2  next-PC select from controller: 00 pc+4, 01 branch, 10 jump, 11 jr
imm  input  16  branch offset (instr[15:0]), word units
jaddr  input  26  jump target field (instr[25:0])
jr_target  input  32  register value for JR
imem_req  output  1  fetch request, valid with imem_addr
imem_addr  output  32  fetch address (= pc)
imem_rvalid  input  1  instruction data valid
imem_rdata  input  32  instruction data
instr  output  32  latched instruction to decode
exec_en  output  1  one-cycle execute strobe (controller enable)
pc  output  32  current PC
pc_plus4  output  32  pc + 4 (JAL link value)
fetch_err  output  1  sticky: a fetch timed out
align_err  output  1  sticky: JR target had nonzero bits [1:0]

Behaviour:
- Reset (reset=1 at clock edge): state=FETCH, pc=RESET_PC, instr=32'h0, wait counter=0, fetch_err=0, align_err=0. Reset overrides everything, including mid-WAIT and mid-EXEC; an rvalid in the reset cycle is ignored.
- imem_req = (state==FETCH) & run. imem_addr = pc. exec_en = (state==EXEC). pc_plus4 = pc + 32'd4, combinational, mod 2^32.
- FETCH:
  - run=0: stay in FETCH.
  - run=1: go to WAIT and clear the counter.
  - Memory never returns rvalid in the request cycle; rvalid seen in FETCH or EXEC is ignored.
- WAIT:
  - imem_rvalid=1: instr <= imem_rdata, go to EXEC.
  - Otherwise counter increments. When counter reaches TIMEOUT-1 without rvalid: fetch_err <= 1, go to FETCH (retry same pc); instr unchanged.
  - Minimum fetch latency is request cycle + 1; instruction period is ≥ 3 cycles.
- EXEC: exec_en=1 for exactly one cycle, then go to FETCH. At the end of EXEC, pc <= next_pc:
  - 00: pc + 4.
  - 01: pc + 4 + (sign_extend(imm) << 2).
  - 10: {pc_plus4[31:28], jaddr, 2'b00}.
  - 11: {jr_target[31:2], 2'b00}. If jr_target[1:0] != 0, align_err <= 1.
  - All adds wrap mod 2^32.
- pcsel, imm, jaddr and jr_target are sampled only in EXEC; ignored in other states.
- instr holds its value from EXEC through the next WAIT until it is overwritten.
- pc[1:0] is always 00.
- Sticky errors clear only on reset.

Test Plan:
- Reset, run=1, memory returns rvalid 1 cycle after req with data 32'h2008_0005 -> imem_addr=32'h0040_0000, instr=32'h2008_0005, exec_en high one cycle at cycle 3; with pcsel=00, next imem_addr=32'h0040_0004.
- Branch: pc=32'h0040_0010, pcsel=01, imm=16'hFFFC -> next pc=32'h0040_0004. imm=16'h0003 -> 32'h0040_0020.
- Jump and JR:
  - pc=32'h0040_0000, pcsel=10, jaddr=26'h010_0008 -> pc=32'h0040_0020.
  - pcsel=11, jr_target=32'h0040_1237 -> pc=32'h0040_1234, align_err=1.
- Timeout: no rvalid for 16 cycles -> fetch_err=1, returns to FETCH, re-requests same address. A later response completes normally; fetch_err stays 1.
- Stall and reset:
  - run=0 -> imem_req=0, exec_en=0, pc frozen.
  - reset asserted in WAIT with rvalid=1 -> instr=0, pc=RESET_PC, no exec_en pulse.
- Wrap: pc=32'hFFFF_FFFC, pcsel=00 -> pc=32'h0000_0000.
